// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Types shared by the five-stage pipeline and its hazard controller:
//   creg_addr_t : 5-bit architectural register index
//   u64         : 64-bit machine word (PCs, data)
//   hc_state_t  : hazard controller redirect FSM state {RUN, DROP}
// plus the event-counter width and a source-match helper used by load-use
// detection.
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

  typedef logic [4:0]  creg_addr_t;
  typedef logic [63:0] u64;

  // RUN : normal operation, redirects are applied immediately.
  // DROP: a redirect is pending behind an outstanding ibus request; the
  //       stale response must be discarded before fetch restarts.
  typedef enum logic [0:0] {
    RUN  = 1'b0,
    DROP = 1'b1
  } hc_state_t;

  localparam int unsigned HC_CNT_W = 32;

  // True when a decode source operand is actually read and names the
  // register being produced in execute.
  function automatic logic src_hit(
    input creg_addr_t rs,
    input logic       use_rs,
    input creg_addr_t dst
  );
    return use_rs & (rs == dst);
  endfunction

endpackage : hazard_ctrl_pkg

// File: rtl/hazard_ctrl_event_counter.sv
// ---------------------------------------------------------------------------
// event_counter
// Free-running wrap-around event counter.
//   clk    : clock
//   resetn : asynchronous active-low reset, clears the count
//   en_i   : count one event this cycle
//   cnt_o  : current count (wraps from all-ones to zero, no saturation)
// ---------------------------------------------------------------------------
module event_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Next count: increment on an event, natural modulo-2^WIDTH wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + WIDTH'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule : event_counter

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Pipeline hazard controller for the five-stage RV64 core. Produces the
// per-stage hold (stall_*) and bubble (flush_*) controls, sequences branch
// redirects that collide with an outstanding instruction fetch, and counts
// stall and flush events.
//
// Inputs : clk, resetn (async, active low)
//          if_busy / if_done         ibus request outstanding / response valid
//          mem_busy / ex_busy        dbus access / multicycle unit not done
//          id_rs1/2, id_use_rs1/2    decode sources and whether they are read
//          ex_valid, ex_is_load, ex_dst  execute-stage instruction info
//          br_taken, br_target       taken branch/jump resolved in execute
// Outputs: stall_if/id/ex/mem        hold the named pipeline register
//          flush_id/ex/wb            load a bubble into the named register
//          discard_fetch             drop the ibus response of this cycle
//          redirect_valid/pc         fetch loads redirect_pc this cycle
//          stall_cnt, flush_cnt      32-bit wrapping event counters
//
// Controls are combinational so a hazard is resolved in the cycle it is
// detected; only the FSM state, the pending redirect target and the
// counters are registered.
// ---------------------------------------------------------------------------
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                resetn,
  input  logic                if_busy,
  input  logic                if_done,
  input  logic                mem_busy,
  input  logic                ex_busy,
  input  creg_addr_t          id_rs1,
  input  creg_addr_t          id_rs2,
  input  logic                id_use_rs1,
  input  logic                id_use_rs2,
  input  logic                ex_valid,
  input  logic                ex_is_load,
  input  creg_addr_t          ex_dst,
  input  logic                br_taken,
  input  u64                  br_target,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                stall_mem,
  output logic                flush_id,
  output logic                flush_ex,
  output logic                flush_wb,
  output logic                discard_fetch,
  output logic                redirect_valid,
  output u64                  redirect_pc,
  output logic [HC_CNT_W-1:0] stall_cnt,
  output logic [HC_CNT_W-1:0] flush_cnt
);

  hc_state_t state_q;
  hc_state_t state_d;
  u64        tgt_q;
  u64        tgt_d;

  logic cond_m;
  logic cond_x;
  logic cond_l;
  logic cond_b;
  logic b_fire;
  logic l_eff;
  logic in_drop;
  logic rs_hit;

  // Hazard conditions in priority order: a busy memory stage freezes the
  // whole pipe, a busy execute unit freezes the front, then branch beats
  // load-use.
  always_comb begin
    cond_m = mem_busy;
    cond_x = ex_busy & ~cond_m;
    rs_hit = src_hit(id_rs1, id_use_rs1, ex_dst) |
             src_hit(id_rs2, id_use_rs2, ex_dst);
    cond_l = ex_valid & ex_is_load & (ex_dst != 5'd0) & rs_hit &
             ~cond_m & ~cond_x;
    cond_b = ex_valid & br_taken & ~cond_m & ~cond_x;
    in_drop = (state_q == DROP);
    // Execute holds a bubble during DROP, so a branch there is not real.
    b_fire = cond_b & ~in_drop;
    // A firing branch flushes the load's consumer, so its stall is moot.
    l_eff  = cond_l & ~b_fire;
  end

  // Redirect sequencing: immediate redirect when no fetch is in flight,
  // otherwise park the target until the stale response returns.
  always_comb begin
    state_d        = state_q;
    tgt_d          = tgt_q;
    redirect_valid = 1'b0;
    redirect_pc    = tgt_q;
    discard_fetch  = 1'b0;
    case (state_q)
      RUN: begin
        if (b_fire) begin
          if (if_busy & ~if_done) begin
            state_d = DROP;
            tgt_d   = br_target;
          end else begin
            // A response landing now belongs to the flushed path; the
            // decode flush kills it.
            redirect_valid = 1'b1;
            redirect_pc    = br_target;
          end
        end else begin
          state_d = RUN;
        end
      end
      DROP: begin
        if (if_done) begin
          discard_fetch  = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = tgt_q;
          state_d        = RUN;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // Per-stage controls. DROP keeps fetch held and decode empty while the
  // later stages follow the ordinary busy/load-use rules.
  always_comb begin
    stall_if  = cond_m | cond_x | l_eff | in_drop;
    stall_id  = cond_m | cond_x | l_eff;
    stall_ex  = cond_m | cond_x;
    // On a multicycle stall the memory register takes a bubble instead.
    stall_mem = cond_m;
    flush_id  = b_fire | in_drop;
    flush_ex  = b_fire | l_eff;
    flush_wb  = cond_m;
  end

  // FSM state and pending redirect target.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= RUN;
      tgt_q   <= 64'd0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
    end
  end

  event_counter #(
    .WIDTH (HC_CNT_W)
  ) u_stall_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (stall_if),
    .cnt_o  (stall_cnt)
  );

  event_counter #(
    .WIDTH (HC_CNT_W)
  ) u_flush_cnt (
    .clk    (clk),
    .resetn (resetn),
    .en_i   (b_fire),
    .cnt_o  (flush_cnt)
  );

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed bench for hazard_ctrl. Inputs change just after the falling
// edge and combinational controls are sampled 1 time unit later; counters
// are sampled at the next falling edge, after the rising edge updated them.
// Control bit order in ctl: stall_if stall_id stall_ex stall_mem flush_id
// flush_ex flush_wb discard_fetch redirect_valid.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  logic        clk;
  logic        resetn;
  logic        if_busy, if_done, mem_busy, ex_busy;
  creg_addr_t  id_rs1, id_rs2, ex_dst;
  logic        id_use_rs1, id_use_rs2, ex_valid, ex_is_load, br_taken;
  u64          br_target;
  logic        stall_if, stall_id, stall_ex, stall_mem;
  logic        flush_id, flush_ex, flush_wb, discard_fetch, redirect_valid;
  u64          redirect_pc;
  logic [31:0] stall_cnt, flush_cnt;
  logic [8:0]  ctl;

  int          n_pass;
  int          n_total;
  logic [31:0] exp_stall;
  logic [31:0] exp_flush;

  localparam logic [8:0] C_IDLE    = 9'b000000000;
  localparam logic [8:0] C_LU      = 9'b110001000;
  localparam logic [8:0] C_BR      = 9'b000011001;
  localparam logic [8:0] C_BR_PARK = 9'b000011000;
  localparam logic [8:0] C_DROP    = 9'b100010000;
  localparam logic [8:0] C_DROP_M  = 9'b111110100;
  localparam logic [8:0] C_DONE_M  = 9'b111110111;
  localparam logic [8:0] C_MEM     = 9'b111100100;
  localparam logic [8:0] C_EXB     = 9'b111000000;

  hazard_ctrl dut (
    .clk            (clk),
    .resetn         (resetn),
    .if_busy        (if_busy),
    .if_done        (if_done),
    .mem_busy       (mem_busy),
    .ex_busy        (ex_busy),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_valid       (ex_valid),
    .ex_is_load     (ex_is_load),
    .ex_dst         (ex_dst),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .stall_if       (stall_if),
    .stall_id       (stall_id),
    .stall_ex       (stall_ex),
    .stall_mem      (stall_mem),
    .flush_id       (flush_id),
    .flush_ex       (flush_ex),
    .flush_wb       (flush_wb),
    .discard_fetch  (discard_fetch),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cnt      (stall_cnt),
    .flush_cnt      (flush_cnt)
  );

  assign ctl = {stall_if, stall_id, stall_ex, stall_mem, flush_id,
                flush_ex, flush_wb, discard_fetch, redirect_valid};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    if_busy = 1'b0; if_done = 1'b0; mem_busy = 1'b0; ex_busy = 1'b0;
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_is_load = 1'b0; ex_dst = 5'd0;
    br_taken = 1'b0; br_target = 64'd0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    clear_inputs();
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL reset_ctl got %b exp %b", ctl, C_IDLE); else n_pass++;
    n_total++; if (redirect_pc !== 64'd0) $display("FAIL reset_pc got %h exp 0", redirect_pc); else n_pass++;
    n_total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL reset_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    exp_stall = 32'd0;
    exp_flush = 32'd0;
  endtask

  task automatic test_load_use();
    @(negedge clk);
    clear_inputs();
    ex_valid = 1'b1; ex_is_load = 1'b1; ex_dst = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
    #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_rs1 got %b exp %b", ctl, C_LU); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    n_total++; if (stall_cnt !== exp_stall) $display("FAIL lu_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
    ex_valid = 1'b0;
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL lu_after got %b exp %b", ctl, C_IDLE); else n_pass++;
    @(negedge clk);
    ex_valid = 1'b1; id_use_rs1 = 1'b0; id_rs1 = 5'd7; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    n_total++; if (ctl !== C_LU) $display("FAIL lu_rs2 got %b exp %b", ctl, C_LU); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    ex_dst = 5'd0; id_rs2 = 5'd0;
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL lu_x0 got %b exp %b", ctl, C_IDLE); else n_pass++;
    @(negedge clk);
    ex_dst = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL lu_unused got %b exp %b", ctl, C_IDLE); else n_pass++;
    @(negedge clk);
    clear_inputs();
    n_total++; if (stall_cnt !== exp_stall) $display("FAIL lu_cnt2 got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
  endtask

  task automatic test_branch();
    @(negedge clk);
    clear_inputs();
    ex_valid = 1'b1; br_taken = 1'b1; br_target = 64'h0000_0000_8000_0040;
    #1;
    n_total++; if (ctl !== C_BR) $display("FAIL br_ctl got %b exp %b", ctl, C_BR); else n_pass++;
    n_total++; if (redirect_pc !== 64'h0000_0000_8000_0040)
      $display("FAIL br_pc got %h exp 0000000080000040", redirect_pc); else n_pass++;
    exp_flush = exp_flush + 32'd1;
    @(negedge clk);
    n_total++; if (flush_cnt !== exp_flush) $display("FAIL br_flush_cnt got %0d exp %0d", flush_cnt, exp_flush); else n_pass++;
    // Branch together with load-use and a response arriving this cycle.
    ex_is_load = 1'b1; ex_dst = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
    if_busy = 1'b1; if_done = 1'b1; br_target = 64'hFFFF_0000_0000_1000;
    #1;
    n_total++; if (ctl !== C_BR) $display("FAIL br_lu_done got %b exp %b", ctl, C_BR); else n_pass++;
    n_total++; if (redirect_pc !== 64'hFFFF_0000_0000_1000)
      $display("FAIL br_lu_pc got %h exp ffff000000001000", redirect_pc); else n_pass++;
    exp_flush = exp_flush + 32'd1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL br_stay_run got %b exp %b", ctl, C_IDLE); else n_pass++;
    n_total++; if (flush_cnt !== exp_flush) $display("FAIL br_flush_cnt2 got %0d exp %0d", flush_cnt, exp_flush); else n_pass++;
    n_total++; if (stall_cnt !== exp_stall) $display("FAIL br_stall_cnt got %0d exp %0d", stall_cnt, exp_stall); else n_pass++;
  endtask

  task automatic test_redirect_drop();
    @(negedge clk);
    clear_inputs();
    ex_valid = 1'b1; br_taken = 1'b1; br_target = 64'h1234_5678_9ABC_DEF0; if_busy = 1'b1;
    #1;
    n_total++; if (ctl !== C_BR_PARK) $display("FAIL drop_enter got %b exp %b", ctl, C_BR_PARK); else n_pass++;
    n_total++; if (redirect_pc !== 64'd0) $display("FAIL drop_enter_pc got %h exp 0", redirect_pc); else n_pass++;
    exp_flush = exp_flush + 32'd1;
    @(negedge clk);
    clear_inputs();
    if_busy = 1'b1; br_target = 64'h0BAD_0BAD_0BAD_0BAD;
    #1;
    n_total++; if (ctl !== C_DROP) $display("FAIL drop_c1 got %b exp %b", ctl, C_DROP); else n_pass++;
    n_total++; if (redirect_pc !== 64'h1234_5678_9ABC_DEF0)
      $display("FAIL drop_tgt got %h exp 123456789abcdef0", redirect_pc); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    mem_busy = 1'b1;
    #1;
    n_total++; if (ctl !== C_DROP_M) $display("FAIL drop_c2_mem got %b exp %b", ctl, C_DROP_M); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    mem_busy = 1'b0;
    #1;
    n_total++; if (ctl !== C_DROP) $display("FAIL drop_c3 got %b exp %b", ctl, C_DROP); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    mem_busy = 1'b1; if_done = 1'b1;
    #1;
    n_total++; if (ctl !== C_DONE_M) $display("FAIL drop_done got %b exp %b", ctl, C_DONE_M); else n_pass++;
    n_total++; if (redirect_pc !== 64'h1234_5678_9ABC_DEF0)
      $display("FAIL drop_done_pc got %h exp 123456789abcdef0", redirect_pc); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    clear_inputs();
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL drop_back_run got %b exp %b", ctl, C_IDLE); else n_pass++;
    n_total++; if (stall_cnt !== exp_stall || flush_cnt !== exp_flush)
      $display("FAIL drop_cnts got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else n_pass++;
  endtask

  task automatic test_mem_busy();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      clear_inputs();
      mem_busy = 1'b1; ex_valid = 1'b1; br_taken = 1'b1; br_target = 64'h0000_0000_0000_0040;
      ex_is_load = 1'b1; ex_dst = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b1;
      #1;
      n_total++; if (ctl !== C_MEM) $display("FAIL mem_c%0d got %b exp %b", i, ctl, C_MEM); else n_pass++;
      exp_stall = exp_stall + 32'd1;
    end
    @(negedge clk);
    n_total++; if (flush_cnt !== exp_flush) $display("FAIL mem_no_flush got %0d exp %0d", flush_cnt, exp_flush); else n_pass++;
    mem_busy = 1'b0;
    #1;
    n_total++; if (ctl !== C_BR || redirect_pc !== 64'h0000_0000_0000_0040)
      $display("FAIL mem_then_br got %b/%h exp %b/40", ctl, redirect_pc, C_BR); else n_pass++;
    exp_flush = exp_flush + 32'd1;
    @(negedge clk);
    clear_inputs();
    n_total++; if (flush_cnt !== exp_flush || stall_cnt !== exp_stall)
      $display("FAIL mem_cnts got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else n_pass++;
  endtask

  task automatic test_ex_busy();
    @(negedge clk);
    clear_inputs();
    ex_busy = 1'b1; ex_valid = 1'b1; br_taken = 1'b1;
    ex_is_load = 1'b1; ex_dst = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1;
    #1;
    n_total++; if (ctl !== C_EXB) $display("FAIL exb_ctl got %b exp %b", ctl, C_EXB); else n_pass++;
    exp_stall = exp_stall + 32'd1;
    @(negedge clk);
    clear_inputs();
    n_total++; if (stall_cnt !== exp_stall || flush_cnt !== exp_flush)
      $display("FAIL exb_cnts got %0d/%0d exp %0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); else n_pass++;
  endtask

  task automatic test_counter_wrap();
    @(negedge clk);
    clear_inputs();
    force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.u_stall_cnt.cnt_q;
    #1;
    n_total++; if (stall_cnt !== 32'hFFFF_FFFF) $display("FAIL wrap_preset got %h exp ffffffff", stall_cnt); else n_pass++;
    mem_busy = 1'b1;
    @(negedge clk);
    n_total++; if (stall_cnt !== 32'd0) $display("FAIL wrap_zero got %h exp 0", stall_cnt); else n_pass++;
    mem_busy = 1'b0;
    @(negedge clk);
    n_total++; if (stall_cnt !== 32'd0) $display("FAIL wrap_hold got %h exp 0", stall_cnt); else n_pass++;
    exp_stall = 32'd0;
  endtask

  task automatic test_reset_in_drop();
    @(negedge clk);
    clear_inputs();
    ex_valid = 1'b1; br_taken = 1'b1; br_target = 64'h0000_0000_0000_0ABC; if_busy = 1'b1;
    @(negedge clk);
    clear_inputs();
    if_busy = 1'b1;
    #1;
    n_total++; if (ctl !== C_DROP) $display("FAIL rst_drop_pre got %b exp %b", ctl, C_DROP); else n_pass++;
    #1;
    resetn = 1'b0;
    #1;
    n_total++; if (ctl !== C_IDLE || redirect_pc !== 64'd0)
      $display("FAIL rst_drop_async got %b/%h exp %b/0", ctl, redirect_pc, C_IDLE); else n_pass++;
    n_total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL rst_drop_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    if_done = 1'b1;
    #1;
    n_total++; if (ctl !== C_IDLE) $display("FAIL rst_no_discard got %b exp %b", ctl, C_IDLE); else n_pass++;
    @(negedge clk);
    clear_inputs();
    n_total++; if (stall_cnt !== 32'd0 || flush_cnt !== 32'd0)
      $display("FAIL rst_after_cnt got %h/%h exp 0/0", stall_cnt, flush_cnt); else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_load_use();
    test_branch();
    test_redirect_drop();
    test_mem_busy();
    test_ex_busy();
    test_counter_wrap();
    test_reset_in_drop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_hazard_ctrl

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline controller for the five-stage RV64 core: it generates per-stage stall and flush controls from bus-busy, multicycle-busy, load-use and branch-redirect conditions. It sequences redirects that collide with an in-flight instruction fetch, and keeps stall and flush event counters. It sits beside the fetch/decode/execute/memory/writeback registers and drives their enables; it contains no datapath except the redirect target latch.

## Interface
- No parameters. Widths come from the shared package: `creg_addr_t` is 5 bits and `u64` is 64 bits.
- `clk` in 1: core clock.
- `resetn` in 1: asynchronous, active-low reset.
- `if_busy` in 1: the ibus request is outstanding.
- `if_done` in 1: the ibus response is valid this cycle.
- `mem_busy` in 1: the dbus access for the memory stage is not finished.
- `ex_busy` in 1: the multicycle execute unit (MUL/DIV) is not finished.
- `id_rs1`, `id_rs2` in 5: source registers of the instruction in decode.
- `id_use_rs1`, `id_use_rs2` in 1: the matching source is actually read.
- `ex_valid` in 1: the execute-stage instruction is valid.
- `ex_is_load` in 1: `ctl.op == LD` in execute.
- `ex_dst` in 5: destination register in execute; 0 means no write.
- `br_taken` in 1: execute resolved a taken branch or jump (JAL, JALR, B*).
- `br_target` in 64: the redirect PC.
- `stall_if`, `stall_id`, `stall_ex`, `stall_mem` out 1: hold that pipeline register.
- `flush_id`, `flush_ex`, `flush_wb` out 1: load a bubble (valid=0) into the decode, execute or writeback register.
- `discard_fetch` out 1: drop the ibus response returning this cycle.
- `redirect_valid` out 1: fetch loads `redirect_pc` this cycle.
- `redirect_pc` out 64: the redirect PC.
- `stall_cnt`, `flush_cnt` out 32: event counters.

## Operation
Conditions, evaluated combinationally each cycle:
- **M**: `M = mem_busy`.
  - Sets stall_if, stall_id, stall_ex and stall_mem, plus flush_wb.
  - Masks every condition below.
- **X**: `X = ex_busy & !M`.
  - Sets stall_if, stall_id and stall_ex.
  - Bubbles into memory. The memory register takes `ex_valid=0`, so stall_mem=0 and the execute output is gated by the memory stage.
- **L** (load-use): `L = ex_valid & ex_is_load & ex_dst!=0 & ((id_use_rs1 & id_rs1==ex_dst) | (id_use_rs2 & id_rs2==ex_dst)) & !M & !X`.
  - Sets stall_if, stall_id and flush_ex.
- **B** (branch fire): `B = ex_valid & br_taken & !M & !X`. B has priority over L.
  - Sets flush_id and flush_ex, which kills the two younger instructions.
  - L's stalls are suppressed that cycle.

FSM states are RUN and DROP.
- **RUN**:
  - On B with `if_busy & !if_done`: latch `br_target` into `tgt_q` and go to DROP. redirect_valid=0.
  - On B otherwise: redirect_valid=1 and redirect_pc=br_target this cycle. Any response arriving this cycle is killed by flush_id.
- **DROP**:
  - stall_if=1 and flush_id=1 every cycle; M/X/L stall rules still apply to the later stages.
  - B cannot occur, because execute holds a bubble.
  - On if_done: discard_fetch=1, redirect_valid=1, redirect_pc=tgt_q, then go to RUN.
- redirect_pc = tgt_q whenever redirect_valid=0.

Counters:
- `stall_cnt` increments in any cycle where stall_if=1.
- `flush_cnt` increments once per B.
- Both are 32-bit, wrap from 0xFFFF_FFFF to 0, and have no saturation.

## Timing
- All stall, flush, discard and redirect outputs are combinational from the inputs and state. The decision and its effect happen in the same cycle.
- The state, tgt_q and the counters update on the rising edge of clk.
- DROP lasts until if_done, with no timeout. The minimum DROP stay is 1 cycle.
- B coincident with if_done in RUN: the redirect is immediate and the state stays RUN.
- B coincident with L: B wins and stall_if=0.
- M asserted during DROP: the state holds, and if_done is still honoured; fetch is independent of dbus.
- Reset (async assert, at any time including mid-DROP):
  - State goes to RUN; tgt_q, stall_cnt and flush_cnt go to 0.
  - Outputs settle to their idle values: all 0, redirect_pc=0.

## Structure
- The `hc_state_t` enum {RUN, DROP} goes in the shared pipeline package.
- The counters are one reusable sub-module, `event_counter`: 32-bit, with enable and async active-low reset. It is instantiated twice.

## Test plan
- Load-use: execute LD with ex_dst=5; decode reads rs1=5 → stall_if=stall_id=flush_ex=1 for one cycle. Next cycle (ex_valid=0), all 0.
- Plain taken branch: br_target=0x8000_0040, if_busy=0 → redirect_valid=1, redirect_pc=0x8000_0040, flush_id=flush_ex=1, and flush_cnt becomes 1.
- Redirect during fetch: B with if_busy=1, if_done=0; if_done arrives 3 cycles later.
  - stall_if=flush_id=1 for 3 cycles.
  - In the if_done cycle: discard_fetch=1, redirect_valid=1, redirect_pc equals the latched target.
- mem_busy for 4 cycles with B and L also asserted → stall_if/id/ex/mem=1 and flush_wb=1 each cycle, with no redirect and no flush_cnt change. B fires in the cycle after mem_busy drops.
- Counter wrap: preset by running 2^32−1 stall cycles (or force) → the next stall cycle makes stall_cnt=0.
- Drop resetn while in DROP → the state returns to RUN asynchronously, all outputs are 0, and a later if_done produces no discard_fetch.
